// File: rtl/tl_ram_adapter_if.sv
// tl_channel: TileLink link bundle carrying A/D plus tied-off B/C/E.
// The device modport is what a slave endpoint such as tl_ram_adapter sees.
interface tl_channel #(
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64,
  parameter int SizeWidth   = 3
) ();
  logic                     a_valid;
  logic                     a_ready;
  logic [2:0]               a_opcode;
  logic [2:0]               a_param;
  logic [SizeWidth-1:0]     a_size;
  logic [SourceWidth-1:0]   a_source;
  logic [AddrWidth-1:0]     a_address;
  logic [DataWidth/8-1:0]   a_mask;
  logic [DataWidth-1:0]     a_data;
  logic                     a_corrupt;

  logic                     d_valid;
  logic                     d_ready;
  logic [2:0]               d_opcode;
  logic [1:0]               d_param;
  logic [SizeWidth-1:0]     d_size;
  logic [SourceWidth-1:0]   d_source;
  logic [SinkWidth-1:0]     d_sink;
  logic                     d_denied;
  logic [DataWidth-1:0]     d_data;
  logic                     d_corrupt;

  logic                     b_valid;
  logic                     b_ready;
  logic                     c_valid;
  logic                     c_ready;
  logic                     e_valid;
  logic                     e_ready;

  modport device (
    input  a_valid, a_opcode, a_param, a_size, a_source,
    input  a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source,
    output d_sink, d_denied, d_data, d_corrupt,
    input  d_ready,
    output b_valid, c_ready, e_ready,
    input  b_ready, c_valid, e_valid
  );

  modport host (
    output a_valid, a_opcode, a_param, a_size, a_source,
    output a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source,
    input  d_sink, d_denied, d_data, d_corrupt,
    output d_ready,
    input  b_valid, c_ready, e_ready,
    output b_ready, c_valid, e_valid
  );
endinterface

// File: rtl/tl_ram_adapter.sv
// tl_ram_adapter: TileLink device endpoint driving a 1-cycle single-port SRAM.
// Define TL_RAM_ADAPTER_RANGE_CHECK_EN to deny accesses beyond the SRAM range.
module tl_ram_adapter #(
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64,
  parameter int SizeWidth   = 3,
  parameter int MaxSize     = 6,
  parameter int RamDepth    = 1024,
  localparam int IdxW = $clog2(RamDepth),
  localparam int NB   = $clog2(DataWidth/8),
  localparam int MW   = DataWidth/8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tl_channel.device            host,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [IdxW-1:0]      sram_addr_o,
  output logic [MW-1:0]        sram_wmask_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int BW = MaxSize - NB + 1;

  localparam logic [2:0] OpPutFull = 3'd0;
  localparam logic [2:0] OpPutPart = 3'd1;
  localparam logic [2:0] OpArith   = 3'd2;
  localparam logic [2:0] OpLogic   = 3'd3;
  localparam logic [2:0] OpGet     = 3'd4;
  localparam logic [2:0] OpIntent  = 3'd5;

  localparam logic [2:0] DAck     = 3'd0;
  localparam logic [2:0] DAckData = 3'd1;
  localparam logic [2:0] DHintAck = 3'd2;

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, ACK, DENY_DRAIN, DENY_DATA
  } state_e;

  function automatic logic [BW-1:0] len_of(
    input logic [SizeWidth-1:0] sz
  );
    int unsigned s;
    s = 32'(sz);
    if (s <= NB) return '0;
    return BW'((32'd1 << (s - NB)) - 32'd1);
  endfunction

  state_e                 state_q;
  logic [BW-1:0]          beat_q;
  logic [BW-1:0]          dcnt_q;
  logic [BW-1:0]          len_q;
  logic [SizeWidth-1:0]   size_q;
  logic [SourceWidth-1:0] src_q;
  logic [IdxW-1:0]        idx_q;
  logic [2:0]             dop_q;
  logic                   denied_q;
  logic                   put_deny_q;

  logic [DataWidth-1:0]   fifo_q [2];
  logic                   wp_q;
  logic                   rp_q;
  logic [1:0]             cnt_q;
  logic                   infl_q;

  logic                   a_ready;
  logic                   a_fire;
  logic                   d_fire;
  logic                   a_oob;
  logic [BW-1:0]          a_len;
  logic [IdxW-1:0]        a_idx;
  logic                   is_put;
  logic                   is_get;
  logic                   is_hint;
  logic                   is_atom;
  logic                   wr_fire;
  logic                   pop;
  logic                   rd_issue;
  logic [2:0]             occ;

  logic                   d_valid;
  logic [2:0]             d_opcode;
  logic                   d_denied;
  logic                   d_corrupt;
  logic [DataWidth-1:0]   d_data;

  assign a_ready = !rst_i &&
                   (state_q == IDLE || state_q == WRITE ||
                    state_q == DENY_DRAIN);
  assign a_fire  = host.a_valid && a_ready;
  assign d_fire  = d_valid && host.d_ready;
  assign a_len   = len_of(host.a_size);
  assign a_idx   = host.a_address[IdxW+NB-1:NB];

`ifdef TL_RAM_ADAPTER_RANGE_CHECK_EN
  assign a_oob = |(host.a_address >> (IdxW + NB));
`else
  assign a_oob = 1'b0;
`endif

  assign is_put  = host.a_opcode == OpPutFull ||
                   host.a_opcode == OpPutPart;
  assign is_get  = host.a_opcode == OpGet;
  assign is_hint = host.a_opcode == OpIntent;
  assign is_atom = host.a_opcode == OpArith ||
                   host.a_opcode == OpLogic;

  assign wr_fire = a_fire &&
                   ((state_q == IDLE && is_put && !a_oob) ||
                    state_q == WRITE);

  // A pop in the same cycle frees a slot, keeping 1 beat/cycle.
  assign occ      = 3'(cnt_q) + 3'(infl_q);
  assign pop      = state_q == READ && d_fire;
  assign rd_issue = !rst_i && state_q == READ &&
                    beat_q <= len_q && cnt_q != 2'd2 &&
                    (occ < 3'd2 || pop);

  assign sram_req_o   = wr_fire || rd_issue;
  assign sram_we_o    = wr_fire;
  assign sram_addr_o  = (state_q == IDLE) ? a_idx :
                        idx_q + IdxW'(beat_q);
  assign sram_wmask_o = host.a_mask;
  assign sram_wdata_o = host.a_data;

  always_comb begin
    d_valid   = 1'b0;
    d_opcode  = DAckData;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    d_data    = '0;
    unique case (state_q)
      ACK: begin
        d_valid  = 1'b1;
        d_opcode = dop_q;
        d_denied = denied_q;
      end
      READ: begin
        d_valid = cnt_q != 2'd0;
        d_data  = fifo_q[rp_q];
      end
      DENY_DATA: begin
        d_valid   = 1'b1;
        d_denied  = 1'b1;
        d_corrupt = 1'b1;
      end
      default: ;
    endcase
    if (rst_i) d_valid = 1'b0;
  end

  assign host.a_ready   = a_ready;
  assign host.d_valid   = d_valid;
  assign host.d_opcode  = d_opcode;
  assign host.d_param   = 2'd0;
  assign host.d_size    = size_q;
  assign host.d_source  = src_q;
  assign host.d_sink    = SinkWidth'(0);
  assign host.d_denied  = d_denied;
  assign host.d_data    = d_data;
  assign host.d_corrupt = d_corrupt;
  assign host.b_valid   = 1'b0;
  assign host.c_ready   = 1'b1;
  assign host.e_ready   = 1'b1;

  always_ff @(posedge clk_i) begin
    if (infl_q) fifo_q[wp_q] <= sram_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      dcnt_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      src_q      <= '0;
      idx_q      <= '0;
      dop_q      <= DAck;
      denied_q   <= 1'b0;
      put_deny_q <= 1'b0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      cnt_q      <= 2'd0;
      infl_q     <= 1'b0;
    end else begin
      infl_q <= rd_issue;
      if (infl_q) wp_q <= ~wp_q;
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(infl_q) - 2'(pop);
      if (rd_issue) beat_q <= beat_q + BW'(1);

      unique case (state_q)
        IDLE: if (a_fire) begin
          len_q      <= a_len;
          size_q     <= host.a_size;
          src_q      <= host.a_source;
          idx_q      <= a_idx;
          beat_q     <= '0;
          dcnt_q     <= '0;
          dop_q      <= DAck;
          denied_q   <= 1'b0;
          put_deny_q <= 1'b0;
          unique case (1'b1)
            is_put && !a_oob: begin
              beat_q  <= BW'(1);
              state_q <= (a_len == '0) ? ACK : WRITE;
            end
            is_put && a_oob: begin
              beat_q     <= BW'(1);
              denied_q   <= 1'b1;
              put_deny_q <= 1'b1;
              state_q    <= (a_len == '0) ? ACK : DENY_DRAIN;
            end
            is_get && !a_oob: state_q <= READ;
            is_get && a_oob:  state_q <= DENY_DATA;
            is_hint: begin
              dop_q   <= DHintAck;
              state_q <= ACK;
            end
            is_atom: begin
              beat_q  <= BW'(1);
              state_q <= (a_len == '0) ? DENY_DATA : DENY_DRAIN;
            end
            default: begin
              denied_q <= 1'b1;
              state_q  <= ACK;
            end
          endcase
        end
        WRITE, DENY_DRAIN: if (a_fire) begin
          if (beat_q == len_q) begin
            beat_q <= '0;
            if (state_q == WRITE || put_deny_q) state_q <= ACK;
            else state_q <= DENY_DATA;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        ACK: if (d_fire) state_q <= IDLE;
        READ, DENY_DATA: if (d_fire) begin
          if (dcnt_q == len_q) begin
            state_q <= IDLE;
            beat_q  <= '0;
            dcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [AddrWidth-1:0] unused_addr;
  logic                 unused_ok;
  assign unused_addr = host.a_address;
  assign unused_ok   = ^{host.a_param, host.a_corrupt, host.b_ready,
                         host.c_valid, host.e_valid, unused_addr};

endmodule

// File: doc/tl_ram_adapter.md
# tl_ram_adapter

TileLink device endpoint that terminates the single device link produced by the host-merging socket and drives a single-port, 1-cycle-latency SRAM macro. It services Get, PutFullData and PutPartialData, including multi-beat bursts up to `MaxSize`, and returns AccessAck/AccessAckData on D. Intent is acknowledged without touching the SRAM; atomics are denied. B/C/E channels are tied off: no coherence traffic terminates here.

## Interface
- `SourceWidth`, default 1: A/D source width.
- `SinkWidth`, default 1: D sink width; `d_sink` is always 0.
- `AddrWidth`, default 56: byte address width.
- `DataWidth`, default 64: beat width. Power of two, at least 8.
- `SizeWidth`, default 3: size field width.
- `MaxSize`, default 6: log2 of the largest burst in bytes.
- `RamDepth`, default 1024: SRAM words. Power of two. `IdxW = $clog2(RamDepth)`. `NB = $clog2(DataWidth/8)`.
- `clk_i`, in, 1: clock. Reset is synchronous and active-high, sampled on `clk_i`.
- `rst_i`, in, 1: synchronous active-high reset.
- `host`, `tl_channel.device`, interface: A in, D out. Constant tie-offs: `b_valid`=0, `c_ready`=1, `e_ready`=1.
- `sram_req_o`, out, 1: access strobe.
- `sram_we_o`, out, 1: 1 means write.
- `sram_addr_o`, out, IdxW: word index.
- `sram_wmask_o`, out, DataWidth/8: byte enables, driven from `a_mask`.
- `sram_wdata_o`, out, DataWidth: write data.
- `sram_rdata_i`, in, DataWidth: read data, valid exactly one cycle after a read strobe.

## Operation
- States: IDLE, WRITE, READ, ACK, DENY_DRAIN, DENY_DATA.
- Beat math:
  - `len = (size <= NB) ? 0 : (1 << (size-NB)) - 1`.
  - Beat counter `beat_q` has width `MaxSize-NB+1`.
  - Word index: `address[IdxW+NB-1:NB] + beat_q`, truncated to IdxW bits (wraps).
- IDLE: `a_ready`=1. On A handshake, latch `opcode`/`size`/`source` and set `beat_q`=0.
  - PutFull/PutPartial: the first beat writes the SRAM in the handshake cycle. If `len==0`, go to ACK; otherwise go to WRITE.
  - Get: go to READ.
  - Intent (5): go to ACK with opcode HintAck (2).
  - Arithmetic/Logical (2/3): go to DENY_DRAIN if `len>0`; otherwise go to DENY_DATA.
  - Opcodes 6/7: go to ACK with AccessAck, `denied`=1.
- WRITE:
  - `a_ready`=1.
  - Each handshake writes: `sram_req_o`=`sram_we_o`=1, combinational from `a_valid && a_ready`.
  - `beat_q` increments per beat. After beat `len`, go to ACK.
- ACK: `d_valid`=1 with a single beat.
  - `d_opcode`: AccessAck (0) for Put, HintAck (2) for Intent.
  - `d_size`/`d_source` come from the latched request. `d_param`=0, `d_sink`=0, `d_corrupt`=0.
  - `a_ready`=0. On D handshake, go to IDLE.
- READ:
  - `a_ready`=0. Holds a 2-entry read-data FIFO and a 1-bit in-flight flag.
  - Issue read beat `beat_q` when `count + inflight < 2` and fewer than `len+1` reads have been issued.
  - `sram_rdata_i` is pushed into the FIFO the cycle after the read is issued.
  - FIFO head drives D: AccessAckData (1), `denied`=0, `corrupt`=0.
  - After D handshake of beat `len`, go to IDLE.
- DENY_DRAIN: `a_ready`=1. Discards data beats with no SRAM access. After beat `len`, go to DENY_DATA.
- DENY_DATA: emits `len+1` AccessAckData beats with `denied`=1, `corrupt`=1, `d_data`=0. Then go to IDLE.
- Simultaneous FIFO push and pop: count is unchanged.
- Reset, including mid-burst: state goes to IDLE. FIFO is emptied, in-flight flag cleared, `beat_q`=0.

## Timing
- Output values during and after reset:
  - `a_ready`=0 while `rst_i` is high; 1 in the first cycle after reset.
  - `d_valid`=0, `sram_req_o`=0, `sram_we_o`=0.
- Put latency: last A beat handshake at cycle t; AccessAck has `d_valid`=1 at t+1.
- Get latency: A handshake at t; first read at t+1; first beat has `d_valid`=1 at t+3.
- Get throughput: 1 beat/cycle while `d_ready`=1.
- Backpressure:
  - `d_ready` low stalls reads; the FIFO never overflows.
  - D fields are held stable while `d_valid && !d_ready`.
- Turnaround: the next A is accepted the cycle after the final D handshake.
- Only one transaction is outstanding at a time.

## Configuration
- `TL_RAM_ADAPTER_RANGE_CHECK_EN` defined: range check is enabled.
  - If `address >> (IdxW+NB)` is nonzero, Get/Put take the deny path: no SRAM access, Put beats are drained.
  - Put response: AccessAck with `denied`=1.
  - Get response: `len+1` beats with `denied`=1, `corrupt`=1.
- `TL_RAM_ADAPTER_RANGE_CHECK_EN` undefined: upper address bits are ignored and the word index wraps modulo RamDepth.

## Test plan
- PutFull size 3 at 0x40 with data 0xA5A5 -> one SRAM write, idx 8. AccessAck at t+1, `source` echoed. Get of 0x40 returns 0xA5A5 at t+3.
- Put size 6 (8 beats) at 0x0 with data i, then Get size 6 with `d_ready` toggling 50% -> 8 beats, data 0..7 in order. FIFO never exceeds 2 entries. No SRAM access while the FIFO is full.
- PutPartial with mask 0x0F -> `sram_wmask_o`=0x0F. A subsequent Get shows only the low 4 bytes changed.
- Arithmetic size 4 (2 beats) -> both beats consumed with no SRAM strobe. Response: 2 AccessAckData beats, `denied`=1, `corrupt`=1. Intent -> HintAck, `denied`=0.
- Assert `rst_i` during beat 3 of an 8-beat Get -> `d_valid`=0 the cycle after reset. A fresh Get then completes correctly.
- With the macro: Get at `RamDepth*8` -> denied, corrupt. Without the macro: returns word 0.
